// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: size encodings, the buffered entry
// record and the lane-formatting helpers used at enqueue time.
package store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef struct packed {
        logic [29:0] addr;   // word address, i.e. byte address [31:2]
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic is_legal(size_e sz, logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic entry_t format_store(size_e sz, logic [31:0] addr, logic [31:0] data);
        entry_t e;
        e.addr = addr[31:2];
        e.data = data;
        e.be   = 4'b1111;
        case (sz)
            SZ_BYTE: begin
                e.data = {4{data[7:0]}};
                e.be   = 4'b0001 << addr[1:0];
            end
            SZ_HALF: begin
                e.data = {2{data[15:0]}};
                e.be   = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides; no pass-through, so
// a full buffer stays not-ready even when the head is popped this cycle.
module store_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid_i & ~full;
    assign pop   = ~empty & out_ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; out_data_o is gated by empty, so stale words never escape.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= in_data_i;
    end

    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty;
    assign out_data_o  = empty ? '0 : mem_q[rd_q];
    assign count_o     = count_q;

endmodule

// File: rtl/store_unit.sv
// Store unit: formats SB/SH/SW requests into aligned, lane-replicated memory
// writes, rejects misaligned or reserved sizes, and buffers writes in a FIFO.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    input  logic [1:0]  req_size_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_be_o,
    output logic        misalign_o,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    size_e            sz;
    logic             accept, legal;
    logic             misalign_q, misalign_d;
    entry_t           enq_entry, head;
    logic [CNT_W-1:0] count;

    assign sz        = size_e'(req_size_i);
    assign accept    = req_valid_i & req_ready_o;
    assign legal     = is_legal(sz, req_addr_i[1:0]);
    assign enq_entry = format_store(sz, req_addr_i, req_data_i);

    // Rejected requests still complete the handshake; they only raise misalign.
    assign misalign_d = accept & ~legal;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

    store_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (accept & legal),
        .in_ready_o  (req_ready_o),
        .in_data_i   (enq_entry),
        .out_valid_o (mem_valid_o),
        .out_ready_i (mem_ready_i),
        .out_data_o  (head),
        .count_o     (count)
    );

    assign mem_addr_o = {head.addr, 2'b00};
    assign mem_data_o = head.data;
    assign mem_be_o   = head.be;
    assign misalign_o = misalign_q;
    assign busy_o     = |count;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of expected memory writes.
module tb_store_unit;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o;
    logic [31:0] req_addr_i, req_data_i;
    logic [1:0]  req_size_i;
    logic        mem_valid_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_be_o;
    logic        misalign_o, busy_o;

    store_unit #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_size_i  (req_size_i),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_be_o    (mem_be_o),
        .misalign_o  (misalign_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t  q[$];
    logic mis_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd0) || (s == 2'd1 && (a % 2) == 0) || (s == 2'd2 && (a % 4) == 0);
    endfunction

    function automatic wr_t model_fmt(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a - (a % 4);
        w.data = d;
        w.be   = 4'hF;
        if (s == 2'd0) begin
            w.data = (d & 32'hFF) * 32'h0101_0101;
            w.be   = 4'((1 << (a % 4)) & 15);
        end else if (s == 2'd1) begin
            w.data = (d & 32'hFFFF) * 32'h0001_0001;
            w.be   = ((a % 4) >= 2) ? 4'hC : 4'h3;
        end
        return w;
    endfunction

    // Inputs are already driven; check outputs, clock once, advance the model.
    task automatic cycle();
        bit          acc, pop, ok;
        logic [1:0]  s;
        logic [31:0] a, d;
        #2;
        check("req_ready", 32'(q.size() < DEPTH), 32'(req_ready_o));
        check("mem_valid", 32'(mem_valid_o), 32'(q.size() != 0));
        check("busy", 32'(busy_o), 32'(q.size() != 0));
        check("misalign", 32'(misalign_o), 32'(mis_exp));
        if (q.size() != 0) begin
            check("mem_addr", mem_addr_o, q[0].addr);
            check("mem_data", mem_data_o, q[0].data);
            check("mem_be", 32'(mem_be_o), 32'(q[0].be));
        end
        acc = req_valid_i && (q.size() < DEPTH);
        pop = (q.size() != 0) && mem_ready_i;
        s = req_size_i; a = req_addr_i; d = req_data_i;
        ok = model_legal(s, a);
        @(posedge clk_i);
        if (pop) void'(q.pop_front());
        if (acc && ok) q.push_back(model_fmt(s, a, d));
        mis_exp = acc && !ok;
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        req_valid_i = v; req_size_i = s; req_addr_i = a; req_data_i = d;
    endtask

    initial begin
        logic [31:0] a;
        rst_i = 1'b0; mem_ready_i = 1'b0; mis_exp = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_valid", 32'(mem_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_data", mem_data_o, 32'h0);
        check("rst_be", 32'(mem_be_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // SB at byte 3 -> top lane
        mem_ready_i = 1'b1;
        drive(1'b1, 2'd0, 32'h1003, 32'hAABBCCDD);
        cycle();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("sb_addr", mem_addr_o, 32'h1000);
        check("sb_data", mem_data_o, 32'hDDDDDDDD);
        check("sb_be", 32'(mem_be_o), 32'h8);
        cycle();

        // SH upper half, then misaligned SH
        drive(1'b1, 2'd1, 32'h2002, 32'h12345678);
        cycle();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("sh_addr", mem_addr_o, 32'h2000);
        check("sh_data", mem_data_o, 32'h56785678);
        check("sh_be", 32'(mem_be_o), 32'hC);
        cycle();
        drive(1'b1, 2'd1, 32'h2001, 32'h12345678);
        cycle();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("mis_pulse", 32'(misalign_o), 32'd1);
        check("mis_noenq", 32'(mem_valid_o), 32'd0);
        cycle();
        check("mis_onecycle", 32'(misalign_o), 32'd0);

        // Back-pressure: fill, stall a third request, outputs hold
        mem_ready_i = 1'b0;
        drive(1'b1, 2'd2, 32'h3000, 32'h11111111);
        cycle();
        drive(1'b1, 2'd2, 32'h3004, 32'h22222222);
        cycle();
        check("full_ready", 32'(req_ready_o), 32'd0);
        drive(1'b1, 2'd2, 32'h3008, 32'h33333333);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_addr", mem_addr_o, 32'h3000);
            check("hold_data", mem_data_o, 32'h11111111);
        end
        mem_ready_i = 1'b1;
        cycle();
        cycle();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cycle();

        // One entry held, then simultaneous push and pop
        mem_ready_i = 1'b0;
        drive(1'b1, 2'd2, 32'h4000, 32'hA0A0A0A0);
        cycle();
        mem_ready_i = 1'b1;
        drive(1'b1, 2'd2, 32'h4004, 32'hB0B0B0B0);
        cycle();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        check("pp_busy", 32'(busy_o), 32'd1);
        check("pp_order", mem_addr_o, 32'h4004);
        cycle();
        cycle();

        // Reset with two pending entries
        mem_ready_i = 1'b0;
        drive(1'b1, 2'd2, 32'h5000, 32'h55555555);
        cycle();
        drive(1'b1, 2'd2, 32'h5004, 32'h66666666);
        cycle();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_valid", 32'(mem_valid_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_ready", 32'(req_ready_o), 32'd1);
        check("arst_addr", mem_addr_o, 32'h0);
        q.delete();
        mis_exp = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
            mem_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("drained", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
